// File: rtl/ann_seq_pkg.sv
// rtl/ann_seq_pkg.sv - state encoding, default sizes and layer-mask slicing for ann_layer_sequencer
package ann_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_FIRE   = 3'd2;
  localparam state_t S_WAIT_N = 3'd3;
  localparam state_t S_ACT    = 3'd4;
  localparam state_t S_WAIT_A = 3'd5;
  localparam state_t S_NEXT   = 3'd6;
  localparam state_t S_DONE   = 3'd7;

  localparam int DEF_N_LAYERS    = 3;
  localparam int DEF_MAX_NEURONS = 9;
  localparam int DEF_LAYER_W     = 2;
  localparam int DEF_TIMEOUT     = 255;

  // Flat masks are zero-extended to this width before slicing
  localparam int MASK_EXT_W = 256;

  // Returns the neuron mask of layer idx (n neurons per layer) in the low bits
  function automatic logic [31:0] layer_slice(input logic [MASK_EXT_W-1:0] mask,
                                              input int unsigned idx,
                                              input int unsigned n);
    return 32'(mask >> (idx * n));
  endfunction

endpackage

// File: rtl/ann_rdy_collect.sv
// rtl/ann_rdy_collect.sv - sticky neuron-ready collector with clear and all-seen compare
module ann_rdy_collect
  import ann_seq_pkg::*;
#(
  parameter int MAX_NEURONS = DEF_MAX_NEURONS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_acc,
  input  logic [MAX_NEURONS-1:0] i_rdy,
  input  logic [MAX_NEURONS-1:0] i_mask,
  output logic                   o_all_seen
);

  logic [MAX_NEURONS-1:0] r_seen;
  logic [MAX_NEURONS-1:0] w_hit;

  assign w_hit = i_rdy & i_mask;
  // The current cycle's ready counts immediately so a layer can leave WAIT_N after one cycle
  assign o_all_seen = ((r_seen | w_hit) == i_mask);

  // Clear wins over accumulate so readies seen while firing never count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen <= '0;
    end else if (i_clr) begin
      r_seen <= '0;
    end else if (i_acc) begin
      r_seen <= r_seen | w_hit;
    end
  end

endmodule

// File: rtl/ann_layer_sequencer.sv
// rtl/ann_layer_sequencer.sv - per-layer load/fire/collect/activate sequencer; optional watchdog via ANN_SEQ_WATCHDOG_EN
module ann_layer_sequencer
  import ann_seq_pkg::*;
#(
  parameter int N_LAYERS    = DEF_N_LAYERS,
  parameter int MAX_NEURONS = DEF_MAX_NEURONS,
  parameter int LAYER_W     = DEF_LAYER_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_cont,
  input  logic                            i_abort,
  input  logic [N_LAYERS*MAX_NEURONS-1:0] i_layer_mask,
  input  logic [MAX_NEURONS-1:0]          i_neuron_rdy,
  input  logic                            i_act_rdy,
  output logic [N_LAYERS-1:0]             o_load_en,
  output logic [MAX_NEURONS-1:0]          o_neuron_en,
  output logic                            o_act_en,
  output logic                            o_out_load,
  output logic [LAYER_W-1:0]              o_layer_idx,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam logic [N_LAYERS-1:0] LOAD_ONE = 1;
  localparam logic [LAYER_W-1:0]  LAST_IDX = LAYER_W'(N_LAYERS - 1);

  // Elaboration guard against parameter sets the slicing and index logic cannot serve
  if ((1 << LAYER_W) < N_LAYERS || MAX_NEURONS > 32 ||
      N_LAYERS * MAX_NEURONS > MASK_EXT_W || TIMEOUT < 1) begin : g_bad_params
    $error("ann_layer_sequencer: unsupported parameter set");
  end

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [LAYER_W-1:0]              r_layer_idx;
  logic [LAYER_W-1:0]              w_idx_nxt;
  logic [N_LAYERS*MAX_NEURONS-1:0] r_mask;
  logic                            w_capture;
  logic [MAX_NEURONS-1:0]          w_cur_mask;
  logic                            w_all_seen;
  logic                            w_wd_expired;

  assign w_cur_mask = MAX_NEURONS'(layer_slice(MASK_EXT_W'(r_mask), 32'(r_layer_idx), MAX_NEURONS));

  ann_rdy_collect #(.MAX_NEURONS(MAX_NEURONS)) u_rdy_collect (
    .clk        (clk),
    .rst        (rst),
    .i_clr      ((r_state == S_FIRE) || (r_state == S_IDLE) || i_abort),
    .i_acc      (r_state == S_WAIT_N),
    .i_rdy      (i_neuron_rdy),
    .i_mask     (w_cur_mask),
    .o_all_seen (w_all_seen)
  );

  // Next-state and layer-index decode; abort overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_layer_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
          w_capture   = 1'b1;
        end
      end
      S_LOAD:   w_state_nxt = S_FIRE;
      S_FIRE:   w_state_nxt = S_WAIT_N;
      S_WAIT_N: begin
        if (w_all_seen)        w_state_nxt = S_ACT;
        else if (w_wd_expired) w_state_nxt = S_IDLE;
      end
      S_ACT:    w_state_nxt = S_WAIT_A;
      S_WAIT_A: begin
        if (i_act_rdy)         w_state_nxt = S_NEXT;
        else if (w_wd_expired) w_state_nxt = S_IDLE;
      end
      S_NEXT: begin
        if (r_layer_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = r_layer_idx + LAYER_W'(1);
        end
      end
      S_DONE: begin
        if (i_cont) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_capture   = 1'b0;
    end
    if (w_state_nxt == S_IDLE) begin
      w_idx_nxt = '0;
    end
  end

  // State, layer index and the per-run mask snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_layer_idx <= '0;
      r_mask      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_layer_idx <= w_idx_nxt;
      if (w_capture) begin
        r_mask <= i_layer_mask;
      end
    end
  end

`ifdef ANN_SEQ_WATCHDOG_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_err;
  logic             w_in_wait;
  logic             w_wd_trip;

  assign w_in_wait    = (r_state == S_WAIT_N) || (r_state == S_WAIT_A);
  assign w_wd_expired = w_in_wait && (r_wd_cnt == CNT_W'(TIMEOUT - 1));
  assign w_wd_trip    = !i_abort && w_wd_expired &&
                        ((r_state == S_WAIT_N && !w_all_seen) ||
                         (r_state == S_WAIT_A && !i_act_rdy));

  // Wait-cycle counter: zero outside the wait states, counts while a wait persists
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (w_in_wait && w_state_nxt == r_state) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Sticky error: set on a watchdog trip, cleared only by a start accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_wd_trip) begin
      r_err <= 1'b1;
    end else if (r_state == S_IDLE && w_capture) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  assign w_wd_expired = 1'b0;
  assign o_err        = 1'b0;
`endif

  assign o_load_en   = (r_state == S_LOAD) ? (LOAD_ONE << r_layer_idx) : '0;
  assign o_neuron_en = (r_state == S_FIRE) ? w_cur_mask : '0;
  assign o_act_en    = (r_state == S_ACT);
  assign o_out_load  = (r_state == S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_layer_idx = r_layer_idx;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb/tb_ann_layer_sequencer.sv - directed self-checking bench for ann_layer_sequencer
`timescale 1ns/1ps
module tb_ann_layer_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cont;
  logic        abort;
  logic [26:0] layer_mask;
  logic [8:0]  neuron_rdy;
  logic        act_rdy;
  logic [2:0]  load_en;
  logic [8:0]  neuron_en;
  logic        act_en;
  logic        out_load;
  logic [1:0]  layer_idx;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  logic [2:0] lg_load [0:63];
  logic [8:0] lg_nen  [0:63];
  logic       lg_act  [0:63];
  logic       lg_done [0:63];
  logic       lg_busy [0:63];
  logic       lg_err  [0:63];
  logic [1:0] lg_idx  [0:63];

  ann_layer_sequencer #(
    .N_LAYERS(3), .MAX_NEURONS(9), .LAYER_W(2), .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_cont       (cont),
    .i_abort      (abort),
    .i_layer_mask (layer_mask),
    .i_neuron_rdy (neuron_rdy),
    .i_act_rdy    (act_rdy),
    .o_load_en    (load_en),
    .o_neuron_en  (neuron_en),
    .o_act_en     (act_en),
    .o_out_load   (out_load),
    .o_layer_idx  (layer_idx),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  // Records outputs at each falling edge after a start; caller has set start=1 already
  task automatic run_log(input int n, input int chg_cyc, input logic [26:0] chg_mask,
                         input int cont_off_cyc, input int start_until);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      lg_load[i] = load_en;   lg_nen[i]  = neuron_en; lg_act[i] = act_en;
      lg_done[i] = done;      lg_busy[i] = busy;      lg_err[i] = err;
      lg_idx[i]  = layer_idx;
      start = (i < start_until);
      if (i == chg_cyc)      layer_mask = chg_mask;
      if (i == cont_off_cyc) cont = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; cont = 0; abort = 0;
    layer_mask = '0; neuron_rdy = '0; act_rdy = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({load_en, neuron_en, act_en, out_load, busy, done, err, layer_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {load_en, neuron_en, act_en, out_load, busy, done, err, layer_idx});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_run();
    logic [2:0] exp_load;
    layer_mask = {3{9'h007}}; neuron_rdy = '0; act_rdy = 0; cont = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int l = 0; l < 3; l++) begin
      exp_load = 3'b001 << l;
      checks++;
      if (load_en !== exp_load || layer_idx !== 2'(l)) begin
        errors++; $display("FAIL basic_load l%0d got %b/%0d want %b/%0d", l, load_en, layer_idx, exp_load, l);
      end
      @(negedge clk);
      checks++;
      if (neuron_en !== 9'h007) begin errors++; $display("FAIL basic_fire l%0d got %h want 007", l, neuron_en); end
      @(negedge clk);
      @(negedge clk); neuron_rdy = 9'h007;
      checks++;
      if (act_en !== 1'b0) begin errors++; $display("FAIL basic_early_act l%0d got %b want 0", l, act_en); end
      @(negedge clk); neuron_rdy = '0;
      checks++;
      if (act_en !== 1'b1) begin errors++; $display("FAIL basic_act l%0d got %b want 1", l, act_en); end
      @(negedge clk);
      @(negedge clk); act_rdy = 1'b1;
      @(negedge clk); act_rdy = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_next l%0d got %b%b want 10", l, busy, done); end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out_load !== 1'b1) begin errors++; $display("FAIL basic_done got %b%b want 11", done, out_load); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || layer_idx !== 2'd0) begin
      errors++; $display("FAIL basic_after_done got %b%b%0d want 000", busy, done, layer_idx);
    end
  endtask

  task automatic test_stale_ready();
    layer_mask = {3{9'h007}}; neuron_rdy = '0; act_rdy = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk); neuron_rdy = 9'h007;
    @(negedge clk); neuron_rdy = 9'h101;
    @(negedge clk);
    checks++;
    if (act_en !== 1'b0) begin errors++; $display("FAIL stale_counted got %b want 0", act_en); end
    neuron_rdy = 9'h002;
    @(negedge clk);
    checks++;
    if (act_en !== 1'b0) begin errors++; $display("FAIL stale_partial got %b want 0", act_en); end
    neuron_rdy = 9'h004;
    @(negedge clk); neuron_rdy = '0; act_rdy = 1'b1;
    checks++;
    if (act_en !== 1'b1) begin errors++; $display("FAIL stale_accum got %b want 1", act_en); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (load_en !== 3'b010) begin errors++; $display("FAIL stale_layer1 got %b want 010", load_en); end
    abort = 1'b1; act_rdy = 1'b0; @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_min_latency();
    layer_mask = {3{9'h007}}; neuron_rdy = 9'h1FF; act_rdy = 1'b1;
    start = 1'b1;
    run_log(21, -1, '0, -1, 10);
    checks++;
    if (lg_act[2] !== 1'b0 || lg_act[3] !== 1'b1) begin
      errors++; $display("FAIL min_act_cycle got %b%b want 01", lg_act[2], lg_act[3]);
    end
    checks++;
    if (lg_idx[12] !== 2'd2 || lg_nen[13] !== 9'h007) begin
      errors++; $display("FAIL min_layer2 got %0d/%h want 2/007", lg_idx[12], lg_nen[13]);
    end
    checks++;
    if (lg_done[17] !== 1'b0 || lg_done[18] !== 1'b1 || lg_busy[19] !== 1'b0) begin
      errors++; $display("FAIL min_done_18 got %b%b%b want 010", lg_done[17], lg_done[18], lg_busy[19]);
    end
  endtask

  task automatic test_zero_mask();
    layer_mask = {9'h007, 9'h000, 9'h007}; neuron_rdy = 9'h1FF; act_rdy = 1'b1;
    start = 1'b1;
    run_log(21, -1, '0, -1, 0);
    checks++;
    if (lg_load[6] !== 3'b010 || lg_nen[7] !== 9'h000 || lg_act[9] !== 1'b1) begin
      errors++; $display("FAIL zero_layer1 got %b/%h/%b want 010/000/1", lg_load[6], lg_nen[7], lg_act[9]);
    end
    checks++;
    if (lg_load[12] !== 3'b100 || lg_nen[13] !== 9'h007 || lg_done[18] !== 1'b1) begin
      errors++; $display("FAIL zero_layer2 got %b/%h/%b want 100/007/1", lg_load[12], lg_nen[13], lg_done[18]);
    end
  endtask

  task automatic test_back_to_back();
    layer_mask = {3{9'h007}}; neuron_rdy = 9'h1FF; act_rdy = 1'b1; cont = 1'b1;
    start = 1'b1;
    run_log(40, 2, {3{9'h0F0}}, 20, 0);
    checks++;
    if (lg_nen[7] !== 9'h007) begin errors++; $display("FAIL cont_mask_run1 got %h want 007", lg_nen[7]); end
    checks++;
    if (lg_done[18] !== 1'b1 || lg_load[19] !== 3'b001 || lg_busy[19] !== 1'b1 || lg_idx[19] !== 2'd0) begin
      errors++; $display("FAIL cont_restart got %b/%b/%b/%0d want 1/001/1/0", lg_done[18], lg_load[19], lg_busy[19], lg_idx[19]);
    end
    checks++;
    if (lg_nen[20] !== 9'h0F0) begin errors++; $display("FAIL cont_mask_run2 got %h want 0f0", lg_nen[20]); end
    checks++;
    if (lg_done[37] !== 1'b1 || lg_busy[38] !== 1'b0) begin
      errors++; $display("FAIL cont_stop got %b%b want 10", lg_done[37], lg_busy[38]);
    end
  endtask

  task automatic test_abort_reset();
    int dones;
    layer_mask = {3{9'h007}}; neuron_rdy = 9'h1FF; act_rdy = 1'b0; cont = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      act_rdy = (c == 4);
      @(negedge clk);
    end
    act_rdy = 1'b0;
    checks++;
    if (layer_idx !== 2'd1 || busy !== 1'b1 || act_en !== 1'b0) begin
      errors++; $display("FAIL abort_pre got %0d%b%b want 110", layer_idx, busy, act_en);
    end
    abort = 1'b1; act_rdy = 1'b1;
    @(negedge clk); abort = 1'b0; act_rdy = 1'b0;
    checks++;
    if (busy !== 1'b0 || layer_idx !== 2'd0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_idle got %b%0d%b%b want 0000", busy, layer_idx, done, err);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_start got %b want 0", busy); end
    dones = 0;
    repeat (20) begin @(negedge clk); if (done === 1'b1) dones++; end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (neuron_en !== 9'h007) begin errors++; $display("FAIL rst_pre_fire got %h want 007", neuron_en); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || neuron_en !== 9'h000 || layer_idx !== 2'd0) begin
      errors++; $display("FAIL rst_midrun got %b/%h/%0d want 0/000/0", busy, neuron_en, layer_idx);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_en !== 3'b000) begin errors++; $display("FAIL rst_release got %b/%b want 0/000", busy, load_en); end
  endtask

  task automatic test_watchdog();
    layer_mask = {3{9'h007}}; neuron_rdy = 9'h1FF; act_rdy = 1'b0; cont = 1'b0;
    start = 1'b1;
    run_log(32, -1, '0, -1, 0);
`ifdef ANN_SEQ_WATCHDOG_EN
    checks++;
    if (lg_busy[19] !== 1'b1 || lg_err[19] !== 1'b0 || lg_busy[20] !== 1'b0 || lg_err[20] !== 1'b1) begin
      errors++; $display("FAIL wd_trip got %b%b%b%b want 1001", lg_busy[19], lg_err[19], lg_busy[20], lg_err[20]);
    end
    checks++;
    if (lg_err[31] !== 1'b1 || lg_done[18] !== 1'b0 || lg_done[20] !== 1'b0) begin
      errors++; $display("FAIL wd_sticky got %b%b%b want 100", lg_err[31], lg_done[18], lg_done[20]);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++;
    if (err !== 1'b0 || load_en !== 3'b001) begin errors++; $display("FAIL wd_clear got %b/%b want 0/001", err, load_en); end
`else
    checks++;
    if (lg_busy[31] !== 1'b1 || lg_err[31] !== 1'b0) begin
      errors++; $display("FAIL nowd_wait got %b%b want 10", lg_busy[31], lg_err[31]);
    end
`endif
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wd_abort got %b want 0", busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_run();
    test_stale_ready();
    test_min_latency();
    test_zero_mask();
    test_back_to_back();
    test_abort_reset();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
